// File: rtl/configure_pkg.sv
// Shared configuration for the Avalon-MM bridge: default timeout and the request payload.
package configure;

  localparam int unsigned avl_timeout = 1023;
  localparam int unsigned AVL_AW      = 32;
  localparam int unsigned AVL_DW      = 32;
  localparam int unsigned AVL_SW      = AVL_DW / 8;

  typedef struct packed {
    logic [AVL_AW-1:0] addr;
    logic [AVL_DW-1:0] wdata;
    logic [AVL_SW-1:0] wstrb;
  } avl_cmd_t;

endpackage

// File: rtl/avl_bridge.sv
// Single-outstanding bridge from the simple valid/ready request port to an Avalon-MM master,
// with a cycle timeout that turns a stalled slave into an error completion.
module avl_bridge
  import configure::*;
#(
  parameter int unsigned TIMEOUT = avl_timeout,
  parameter bit          WRESP   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              avl_valid,
  input  logic              avl_instr,
  input  logic [AVL_AW-1:0] avl_addr,
  input  logic [AVL_DW-1:0] avl_wdata,
  input  logic [AVL_SW-1:0] avl_wstrb,
  output logic [AVL_DW-1:0] avl_rdata,
  output logic              avl_ready,
  output logic              avl_error,
  output logic [AVL_AW-1:0] m_avl_address,
  output logic [AVL_SW-1:0] m_avl_byteenable,
  output logic              m_avl_lock,
  output logic              m_avl_read,
  output logic [AVL_DW-1:0] m_avl_writedata,
  output logic              m_avl_write,
  output logic [2:0]        m_avl_burstcount,
  input  logic [AVL_DW-1:0] m_avl_readdata,
  input  logic [1:0]        m_avl_response,
  input  logic              m_avl_waitrequest,
  input  logic              m_avl_readdatavalid,
  input  logic              m_avl_writeresponsevalid
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  avl_cmd_t         w_cmd;
  logic             w_is_wr;
  logic             w_resp_hit;
  logic             w_expired;
  logic             w_unused;

  assign w_cmd      = '{addr: {avl_addr[AVL_AW-1:2], 2'b00}, wdata: avl_wdata, wstrb: avl_wstrb};
  assign w_is_wr    = |avl_wstrb;
  assign w_resp_hit = r_is_wr ? m_avl_writeresponsevalid : m_avl_readdatavalid;
  assign w_expired  = (r_cnt == CNT_W'(TIMEOUT));
  // Instruction flag and sub-word address bits travel with the request but steer nothing.
  assign w_unused   = ^{avl_instr, avl_addr[1:0]};

  assign m_avl_lock       = 1'b0;
  assign m_avl_burstcount = 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_is_wr          <= 1'b0;
      avl_ready        <= 1'b0;
      avl_error        <= 1'b0;
      avl_rdata        <= '0;
      m_avl_read       <= 1'b0;
      m_avl_write      <= 1'b0;
      m_avl_address    <= '0;
      m_avl_byteenable <= '0;
      m_avl_writedata  <= '0;
    end else begin
      avl_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (avl_valid) begin
            r_is_wr          <= w_is_wr;
            r_cnt            <= '0;
            m_avl_address    <= w_cmd.addr;
            m_avl_byteenable <= w_is_wr ? w_cmd.wstrb : {AVL_SW{1'b1}};
            m_avl_writedata  <= w_cmd.wdata;
            m_avl_read       <= ~w_is_wr;
            m_avl_write      <= w_is_wr;
            r_state          <= S_REQ;
          end
        end
        S_REQ: begin
          // Slave acceptance wins over an expiring counter; the counter saturates at TIMEOUT.
          if (!m_avl_waitrequest) begin
            m_avl_read  <= 1'b0;
            m_avl_write <= 1'b0;
            if (!w_expired) r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_wr && !WRESP) begin
              avl_rdata <= '0;
              avl_error <= 1'b0;
              avl_ready <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_RESP;
            end
          end else if (w_expired) begin
            m_avl_read  <= 1'b0;
            m_avl_write <= 1'b0;
            avl_rdata   <= '0;
            avl_error   <= 1'b1;
            avl_ready   <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          // A response landing on the expiry cycle still completes normally.
          if (w_resp_hit) begin
            avl_rdata <= r_is_wr ? '0 : m_avl_readdata;
            avl_error <= (m_avl_response != 2'b00);
            avl_ready <= 1'b1;
            r_state   <= S_DONE;
          end else if (w_expired) begin
            avl_rdata <= '0;
            avl_error <= 1'b1;
            avl_ready <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avl_bridge.sv
// Randomised bench for avl_bridge: two instances (write response waited / not waited) share stimulus
// and are checked against a transaction-level timing model.
module tb_avl_bridge;

  localparam int TMO = 8;
  localparam int WIN = 26;

  logic        clock = 1'b0;
  logic        reset;
  logic        avl_valid, avl_instr;
  logic [31:0] avl_addr, avl_wdata;
  logic [3:0]  avl_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  m_resp;
  logic        m_wait, m_rvalid, m_bvalid;

  logic [31:0] o_rdata [2];
  logic        o_ready [2];
  logic        o_error [2];
  logic [31:0] o_addr  [2];
  logic [3:0]  o_be    [2];
  logic        o_lock  [2];
  logic        o_read  [2];
  logic [31:0] o_wd    [2];
  logic        o_write [2];
  logic [2:0]  o_burst [2];

  int n_cmp = 0;
  int n_bad = 0;

  int          ob_rdy_cnt [2];
  int          ob_rdy_cyc [2];
  logic [31:0] ob_rdy_data[2];
  logic        ob_rdy_err [2];
  int          ob_cmd_cnt [2];
  int          ob_cmd_first[2];
  int          ob_cmd_last[2];
  logic [31:0] ob_addr    [2];
  logic [31:0] ob_wd      [2];
  logic [3:0]  ob_be      [2];
  logic        ob_wr      [2];
  logic        ob_stable  [2];

  always #5 clock = ~clock;

  avl_bridge #(.TIMEOUT(TMO), .WRESP(1'b1)) dut_wr1 (
    .clock(clock), .reset(reset), .avl_valid(avl_valid), .avl_instr(avl_instr),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_wstrb(avl_wstrb),
    .avl_rdata(o_rdata[0]), .avl_ready(o_ready[0]), .avl_error(o_error[0]),
    .m_avl_address(o_addr[0]), .m_avl_byteenable(o_be[0]), .m_avl_lock(o_lock[0]),
    .m_avl_read(o_read[0]), .m_avl_writedata(o_wd[0]), .m_avl_write(o_write[0]),
    .m_avl_burstcount(o_burst[0]), .m_avl_readdata(m_rdata), .m_avl_response(m_resp),
    .m_avl_waitrequest(m_wait), .m_avl_readdatavalid(m_rvalid),
    .m_avl_writeresponsevalid(m_bvalid)
  );

  avl_bridge #(.TIMEOUT(TMO), .WRESP(1'b0)) dut_wr0 (
    .clock(clock), .reset(reset), .avl_valid(avl_valid), .avl_instr(avl_instr),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_wstrb(avl_wstrb),
    .avl_rdata(o_rdata[1]), .avl_ready(o_ready[1]), .avl_error(o_error[1]),
    .m_avl_address(o_addr[1]), .m_avl_byteenable(o_be[1]), .m_avl_lock(o_lock[1]),
    .m_avl_read(o_read[1]), .m_avl_writedata(o_wd[1]), .m_avl_write(o_write[1]),
    .m_avl_burstcount(o_burst[1]), .m_avl_readdata(m_rdata), .m_avl_response(m_resp),
    .m_avl_waitrequest(m_wait), .m_avl_readdatavalid(m_rvalid),
    .m_avl_writeresponsevalid(m_bvalid)
  );

  // Transaction-level model. Cycle 0 = avl_valid cycle, command visible from cycle 1, w = waitrequest
  // cycles, response offered at cycle 2+w+d. The counter reads c-1 in cycle c and stops at TMO.
  task automatic model(input logic wr, input logic wresp, input int w, input int d,
                       input logic [1:0] resp, input logic [31:0] rd,
                       output int rc, output logic err, output logic [31:0] data, output int last);
    int resp_end;
    if (w > TMO) begin
      last = TMO + 1; rc = TMO + 2; err = 1'b1; data = '0;
    end else begin
      last = 1 + w;
      if (wr && !wresp) begin
        rc = 2 + w; err = 1'b0; data = '0;
      end else begin
        resp_end = (TMO + 1 > 2 + w) ? TMO + 1 : 2 + w;
        if (2 + w + d <= resp_end) begin
          rc = 3 + w + d; err = (resp != 2'b00); data = wr ? 32'h0 : rd;
        end else begin
          rc = resp_end + 1; err = 1'b1; data = '0;
        end
      end
    end
  endtask

  task automatic observe(input int c);
    for (int i = 0; i < 2; i++) begin
      if (o_ready[i]) begin
        ob_rdy_cnt[i]++; ob_rdy_cyc[i] = c; ob_rdy_data[i] = o_rdata[i]; ob_rdy_err[i] = o_error[i];
      end
      if (o_read[i] || o_write[i]) begin
        if (ob_cmd_cnt[i] == 0) begin
          ob_cmd_first[i] = c; ob_addr[i] = o_addr[i]; ob_wd[i] = o_wd[i];
          ob_be[i] = o_be[i]; ob_wr[i] = o_write[i];
        end else if ({o_addr[i], o_wd[i], o_be[i], o_write[i]} !== {ob_addr[i], ob_wd[i], ob_be[i], ob_wr[i]}) begin
          ob_stable[i] = 1'b0;
        end
        if ((o_read[i] && o_write[i]) || o_lock[i] !== 1'b0 || o_burst[i] !== 3'd1) ob_stable[i] = 1'b0;
        ob_cmd_last[i] = c;
        ob_cmd_cnt[i]++;
      end
    end
  endtask

  // Runs one request over a fixed window, acting as the Avalon slave and recording what the DUTs did.
  task automatic drive_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input int w, input int d, input logic [1:0] resp,
                           input logic [31:0] rd, input logic noise);
    int rc;
    rc = 2 + w + d;
    for (int i = 0; i < 2; i++) begin
      ob_rdy_cnt[i] = 0; ob_rdy_cyc[i] = -1; ob_rdy_data[i] = '0; ob_rdy_err[i] = 1'b0;
      ob_cmd_cnt[i] = 0; ob_cmd_first[i] = -1; ob_cmd_last[i] = -1; ob_stable[i] = 1'b1;
      ob_addr[i] = '0; ob_wd[i] = '0; ob_be[i] = '0; ob_wr[i] = 1'b0;
    end
    for (int c = 0; c < WIN; c++) begin
      @(negedge clock);
      observe(c);
      avl_valid = (c == 0) || (noise && c == 2);
      avl_instr = 1'($urandom);
      avl_addr  = (c == 0) ? addr : $urandom;
      avl_wdata = (c == 0) ? wd : $urandom;
      avl_wstrb = (c == 0) ? strb : 4'($urandom);
      m_wait    = (c >= 1 && c <= w);
      m_rvalid  = (!wr && c == rc) || (noise && c == 1);
      m_bvalid  = (wr && c == rc) || (noise && c == 1);
      m_resp    = (c == rc) ? resp : 2'($urandom);
      m_rdata   = (c == rc) ? rd : $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; avl_valid = 1'b0; avl_instr = 1'b0; avl_addr = '0; avl_wdata = '0; avl_wstrb = '0;
    m_wait = 1'b0; m_rvalid = 1'b0; m_bvalid = 1'b0; m_resp = '0; m_rdata = '0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({o_ready[i], o_error[i], o_rdata[i]} !== 34'h0) begin
        n_bad++; $display("FAIL reset_upstream inst%0d got ready=%b err=%b rdata=%h want 0/0/0", i, o_ready[i], o_error[i], o_rdata[i]);
      end
      n_cmp++;
      if ({o_read[i], o_write[i], o_lock[i], o_addr[i], o_be[i], o_wd[i]} !== 71'h0) begin
        n_bad++; $display("FAIL reset_command inst%0d got rd=%b wr=%b lock=%b addr=%h be=%h wd=%h want all 0", i, o_read[i], o_write[i], o_lock[i], o_addr[i], o_be[i], o_wd[i]);
      end
      n_cmp++;
      if (o_burst[i] !== 3'd1) begin
        n_bad++; $display("FAIL reset_burstcount inst%0d got %0d want 1", i, o_burst[i]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_read_basic();
    drive_txn(1'b0, 32'h0000_0106, $urandom, 4'h0, 0, 0, 2'b00, 32'hCAFE_BABE, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({ob_addr[i], ob_be[i], ob_wr[i]} !== {32'h0000_0104, 4'hF, 1'b0}) begin
        n_bad++; $display("FAIL read_basic_cmd inst%0d got addr=%h be=%h wr=%b want 00000104/f/0", i, ob_addr[i], ob_be[i], ob_wr[i]);
      end
      n_cmp++;
      if (ob_cmd_first[i] != 1 || ob_cmd_cnt[i] != 1) begin
        n_bad++; $display("FAIL read_basic_cmd_cycles inst%0d got first=%0d cnt=%0d want 1/1", i, ob_cmd_first[i], ob_cmd_cnt[i]);
      end
      n_cmp++;
      if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != 3) begin
        n_bad++; $display("FAIL read_basic_ready inst%0d got cnt=%0d cycle=%0d want 1/3", i, ob_rdy_cnt[i], ob_rdy_cyc[i]);
      end
      n_cmp++;
      if ({ob_rdy_data[i], ob_rdy_err[i]} !== {32'hCAFE_BABE, 1'b0}) begin
        n_bad++; $display("FAIL read_basic_data inst%0d got rdata=%h err=%b want cafebabe/0", i, ob_rdy_data[i], ob_rdy_err[i]);
      end
    end
  endtask

  task automatic test_write_wait();
    int exp_cyc[2] = '{9, 7};
    logic exp_err[2] = '{1'b1, 1'b0};
    drive_txn(1'b1, 32'h0000_2003, 32'h1234_5678, 4'b0011, 5, 1, 2'b10, $urandom, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ob_cmd_first[i] != 1 || ob_cmd_cnt[i] != 6 || ob_cmd_last[i] != 6 || ob_stable[i] !== 1'b1) begin
        n_bad++; $display("FAIL write_wait_hold inst%0d got first=%0d cnt=%0d stable=%b want 1/6/1", i, ob_cmd_first[i], ob_cmd_cnt[i], ob_stable[i]);
      end
      n_cmp++;
      if ({ob_addr[i], ob_be[i], ob_wd[i], ob_wr[i]} !== {32'h0000_2000, 4'b0011, 32'h1234_5678, 1'b1}) begin
        n_bad++; $display("FAIL write_wait_cmd inst%0d got addr=%h be=%h wd=%h wr=%b want 00002000/3/12345678/1", i, ob_addr[i], ob_be[i], ob_wd[i], ob_wr[i]);
      end
      n_cmp++;
      if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != exp_cyc[i] || ob_rdy_err[i] !== exp_err[i] || ob_rdy_data[i] !== 32'h0) begin
        n_bad++; $display("FAIL write_wait_done inst%0d got cnt=%0d cycle=%0d err=%b rdata=%h want 1/%0d/%b/0", i, ob_rdy_cnt[i], ob_rdy_cyc[i], ob_rdy_err[i], ob_rdy_data[i], exp_cyc[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // {waitrequest cycles, response delay, expected last command cycle, expected ready cycle, expected error}
    int cases[3][5] = '{'{0, 20, 1, 10, 1}, '{12, 0, 9, 10, 1}, '{0, 7, 1, 10, 0}};
    logic [31:0] rd;
    for (int k = 0; k < 3; k++) begin
      rd = $urandom | 32'h1;
      drive_txn(1'b0, $urandom, $urandom, 4'h0, cases[k][0], cases[k][1], 2'b00, rd, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (ob_cmd_cnt[i] != cases[k][2] || ob_cmd_last[i] != cases[k][2]) begin
          n_bad++; $display("FAIL timeout%0d_cmd inst%0d got cnt=%0d last=%0d want %0d", k, i, ob_cmd_cnt[i], ob_cmd_last[i], cases[k][2]);
        end
        n_cmp++;
        if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != cases[k][3] || ob_rdy_err[i] !== 1'(cases[k][4])
            || ob_rdy_data[i] !== (cases[k][4] != 0 ? 32'h0 : rd)) begin
          n_bad++; $display("FAIL timeout%0d_done inst%0d got cnt=%0d cycle=%0d err=%b rdata=%h want 1/%0d/%0d", k, i, ob_rdy_cnt[i], ob_rdy_cyc[i], ob_rdy_err[i], ob_rdy_data[i], cases[k][3], cases[k][4]);
        end
      end
    end
  endtask

  task automatic test_valid_in_resp();
    logic [31:0] addr;
    addr = $urandom;
    drive_txn(1'b0, addr, $urandom, 4'h0, 0, 4, 2'b00, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ob_cmd_cnt[i] != 1 || ob_addr[i] !== {addr[31:2], 2'b00}) begin
        n_bad++; $display("FAIL valid_in_resp_cmd inst%0d got cnt=%0d addr=%h want 1/%h", i, ob_cmd_cnt[i], ob_addr[i], {addr[31:2], 2'b00});
      end
      n_cmp++;
      if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != 7 || ob_rdy_data[i] !== 32'h0BAD_F00D) begin
        n_bad++; $display("FAIL valid_in_resp_done inst%0d got cnt=%0d cycle=%0d rdata=%h want 1/7/0badf00d", i, ob_rdy_cnt[i], ob_rdy_cyc[i], ob_rdy_data[i]);
      end
    end
  endtask

  task automatic test_reset_midreq();
    int rdy[2] = '{0, 0};
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (o_ready[i]) rdy[i]++;
        if (c == 3 || c == 4) begin
          n_cmp++;
          if (o_read[i] !== (c == 3)) begin
            n_bad++; $display("FAIL reset_midreq_read inst%0d cycle%0d got %b want %b", i, c, o_read[i], c == 3);
          end
        end
      end
      avl_valid = (c == 0);
      avl_addr  = $urandom;
      avl_wstrb = 4'h0;
      m_wait    = (c >= 1);
      m_rvalid  = 1'b0;
      m_bvalid  = 1'b0;
      reset     = (c == 3);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (rdy[i] != 0) begin
        n_bad++; $display("FAIL reset_midreq_ready inst%0d got %0d pulses want 0", i, rdy[i]);
      end
    end
    drive_txn(1'b0, 32'h0000_0040, $urandom, 4'h0, 1, 0, 2'b00, 32'h5A5A_1234, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != 4 || ob_rdy_data[i] !== 32'h5A5A_1234 || ob_rdy_err[i] !== 1'b0) begin
        n_bad++; $display("FAIL reset_midreq_next inst%0d got cnt=%0d cycle=%0d rdata=%h err=%b want 1/4/5a5a1234/0", i, ob_rdy_cnt[i], ob_rdy_cyc[i], ob_rdy_data[i], ob_rdy_err[i]);
      end
    end
  endtask

  task automatic test_wresp0();
    int exp_cyc[2] = '{5, 2};
    logic exp_err[2] = '{1'b1, 1'b0};
    drive_txn(1'b1, $urandom, $urandom, 4'hF, 0, 2, 2'b11, $urandom, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ob_cmd_first[i] != 1 || ob_cmd_cnt[i] != 1 || ob_wr[i] !== 1'b1) begin
        n_bad++; $display("FAIL wresp0_cmd inst%0d got first=%0d cnt=%0d wr=%b want 1/1/1", i, ob_cmd_first[i], ob_cmd_cnt[i], ob_wr[i]);
      end
      n_cmp++;
      if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != exp_cyc[i] || ob_rdy_err[i] !== exp_err[i]) begin
        n_bad++; $display("FAIL wresp0_done inst%0d got cnt=%0d cycle=%0d err=%b want 1/%0d/%b", i, ob_rdy_cnt[i], ob_rdy_cyc[i], ob_rdy_err[i], exp_cyc[i], exp_err[i]);
      end
    end
  endtask

  task automatic test_random();
    logic        wr, noise, e_err;
    logic [1:0]  resp;
    logic [3:0]  strb;
    logic [31:0] addr, wd, rd, e_data;
    int          w, d, e_rc, e_last;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1)); noise = 1'($urandom_range(0, 1));
      strb = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      w = $urandom_range(0, 10); d = $urandom_range(0, 10);
      resp = 2'($urandom); addr = $urandom; wd = $urandom; rd = $urandom;
      drive_txn(wr, addr, wd, strb, w, d, resp, rd, noise);
      for (int i = 0; i < 2; i++) begin
        model(wr, (i == 0), w, d, resp, rd, e_rc, e_err, e_data, e_last);
        n_cmp++;
        if (ob_cmd_first[i] != 1 || ob_cmd_last[i] != e_last || ob_cmd_cnt[i] != e_last || ob_stable[i] !== 1'b1) begin
          n_bad++; $display("FAIL rand%0d_cmd_cycles inst%0d got first=%0d last=%0d cnt=%0d stable=%b want 1/%0d/%0d/1", n, i, ob_cmd_first[i], ob_cmd_last[i], ob_cmd_cnt[i], ob_stable[i], e_last, e_last);
        end
        n_cmp++;
        if ({ob_addr[i], ob_be[i], ob_wd[i], ob_wr[i]} !== {addr[31:2], 2'b00, (wr ? strb : 4'hF), wd, wr}) begin
          n_bad++; $display("FAIL rand%0d_cmd inst%0d got addr=%h be=%h wd=%h wr=%b want %h/%h/%h/%b", n, i, ob_addr[i], ob_be[i], ob_wd[i], ob_wr[i], {addr[31:2], 2'b00}, (wr ? strb : 4'hF), wd, wr);
        end
        n_cmp++;
        if (ob_rdy_cnt[i] != 1 || ob_rdy_cyc[i] != e_rc) begin
          n_bad++; $display("FAIL rand%0d_ready inst%0d got cnt=%0d cycle=%0d want 1/%0d (w=%0d d=%0d wr=%b)", n, i, ob_rdy_cnt[i], ob_rdy_cyc[i], e_rc, w, d, wr);
        end
        n_cmp++;
        if ({ob_rdy_data[i], ob_rdy_err[i]} !== {e_data, e_err}) begin
          n_bad++; $display("FAIL rand%0d_result inst%0d got rdata=%h err=%b want %h/%b", n, i, ob_rdy_data[i], ob_rdy_err[i], e_data, e_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_wait();
    test_timeout();
    test_valid_in_resp();
    test_reset_midreq();
    test_wresp0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
